md_seq: RTL and testbench

- Multi-cycle sequential multiply/divide unit with HI/LO registers; replaces the single-cycle MD path in the CPU EX stage.
- Accepts the same 3-bit op code the pipeline already issues.
- The pipeline issues an op; the unit answers with busy/done and serves HI/LO to the mfhi/mflo read path.
- Shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/md_pkg.sv | 11 +
 rtl/md_seq_step.sv | 20 ++
 rtl/md_seq.sv | 84 ++++++++
 tb/tb_md_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared op codes, state encoding and width for the multiply/divide unit
package md_pkg;
  localparam int WIDTH = 32;
  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
endpackage

// File: rtl/md_seq_step.sv
// md_seq_step: one shift-add multiply or restoring divide iteration on a 2*WIDTH accumulator (is_div, acc, b in; acc_next out)
module md_seq_step #(
  parameter int WIDTH = md_pkg::WIDTH
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   acc_next
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic           ge;
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
    rem      = acc[2*WIDTH-1:WIDTH-1];
    ge       = rem >= {1'b0, b};
    acc_next = is_div ? {ge ? WIDTH'(rem - {1'b0, b}) : rem[WIDTH-1:0], acc[WIDTH-2:0], ge}
                      : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/md_seq.sv
// md_seq: multi-cycle signed/unsigned multiply and divide with HI/LO registers (clk, rst_n, start, mdop, da, db in; busy, done, hi, lo out)
module md_seq #(
  parameter int WIDTH = md_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mdop,
  input  logic [WIDTH-1:0] da,
  input  logic [WIDTH-1:0] db,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import md_pkg::*;
  localparam int CW = $clog2(WIDTH);
  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_q, neg_r, sgn;
  logic [2*WIDTH-1:0] acc, acc_next, prod;
  logic [WIDTH-1:0]   b_r, ma, mb, q_fix, r_fix;
  md_seq_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .b        (b_r),
    .acc_next (acc_next)
  );
  always_comb begin
    sgn   = (mdop == MD_MULT) || (mdop == MD_DIV);
    ma    = sgn && da[WIDTH-1] ? -da : da;
    mb    = sgn && db[WIDTH-1] ? -db : db;
    prod  = neg_q ? -acc : acc;
    q_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  // Multiply keeps the multiplier in acc's low half and the multiplicand in b_r;
  // divide keeps the dividend in acc's low half and the divisor in b_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      b_r    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (mdop == MD_MTHI) hi <= da;
          else if (mdop == MD_MTLO) lo <= da;
          else if (!mdop[2]) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= mdop[1];
            neg_q  <= sgn & (da[WIDTH-1] ^ db[WIDTH-1]);
            neg_r  <= sgn & da[WIDTH-1];
            acc    <= {{WIDTH{1'b0}}, mdop[1] ? ma : mb};
            b_r    <= mdop[1] ? mb : ma;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          {hi, lo} <= is_div ? {r_fix, q_fix} : prod;
          state    <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq: self-checking bench for md_seq with directed and randomized ops against an arithmetic reference model
module tb_md_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdop = 3'b000;
  logic [31:0] da = '0;
  logic [31:0] db = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int checks = 0;
  int errors = 0;

  md_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mdop(mdop),
    .da(da), .db(db), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: return 64'(sa * sb);
      3'b001: return {32'b0, a} * {32'b0, b};
      3'b010: begin
        if (b == 0) return {a, (a[31] ? 32'h1 : 32'hFFFFFFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
    endcase
  endfunction

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit poke);
    int busy_n, done_n, done_i;
    bit leak;
    logic [31:0] oh, ol;
    busy_n = 0; done_n = 0; done_i = -1; leak = 0;
    @(negedge clk);
    oh = hi; ol = lo;
    start = 1'b1; mdop = op; da = a; db = b;
    @(negedge clk);
    start = 1'b0; da = $urandom; db = $urandom;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_n++;
      if (done) begin done_n++; done_i = i; end
      if (busy && (hi !== oh || lo !== ol)) leak = 1;
      if (poke && i == 5) begin start = 1'b1; mdop = 3'b100; da = 32'hDEADBEEF; end
      if (poke && i == 7) begin start = 1'b1; mdop = 3'b001; da = 32'h0BAD0BAD; end
      if (poke && i == 9) start = 1'b0;
      @(negedge clk);
    end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s hi: got %h expected %h", name, hi, exp_hi); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s lo: got %h expected %h", name, lo, exp_lo); end
    checks++; if (busy_n != 33) begin errors++; $display("FAIL %s busy cycles: got %0d expected 33", name, busy_n); end
    checks++; if (done_n != 1 || done_i != 33) begin errors++; $display("FAIL %s done pulse: count %0d at %0d expected 1 at 33", name, done_n, done_i); end
    checks++; if (leak) begin errors++; $display("FAIL %s hi/lo changed while busy: got 1 expected 0", name); end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset busy/done: got %b%b expected 00", busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset hi/lo: got %h/%h expected 0/0", hi, lo); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_op("mult -2*3",  3'b000, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    do_op("multu max",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    do_op("div -7/2",   3'b010, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    do_op("div 7/-2",   3'b010, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
    do_op("divu 100/0", 3'b011, 32'd100,      32'h0,        32'd100,      32'hFFFFFFFF, 0);
    do_op("div 7/0",    3'b010, 32'h7,        32'h0,        32'h7,        32'hFFFFFFFF, 0);
    do_op("div ovf",    3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 0);
  endtask

  task automatic test_move();
    bit seen_busy;
    seen_busy = 0;
    @(negedge clk);
    start = 1'b1; mdop = 3'b100; da = 32'h1234;
    @(negedge clk);
    seen_busy |= busy;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi: got %h expected %h", hi, 32'h1234); end
    mdop = 3'b101; da = 32'h5678;
    @(negedge clk);
    seen_busy |= busy;
    start = 1'b0;
    checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo: got %h expected %h", lo, 32'h5678); end
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mtlo kept hi: got %h expected %h", hi, 32'h1234); end
    checks++; if (seen_busy || done) begin errors++; $display("FAIL move busy/done: got %b%b expected 00", seen_busy, done); end
  endtask

  task automatic test_reserved();
    bit seen_busy;
    seen_busy = 0;
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      start = 1'b1; mdop = 3'(k); da = $urandom; db = $urandom;
      repeat (3) begin @(negedge clk); seen_busy |= busy | done; end
      start = 1'b0;
    end
    @(negedge clk);
    checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin errors++; $display("FAIL reserved hi/lo: got %h/%h expected 00001234/00005678", hi, lo); end
    checks++; if (seen_busy) begin errors++; $display("FAIL reserved busy/done: got 1 expected 0"); end
  endtask

  task automatic test_busy_ignore();
    do_op("start while busy", 3'b000, 32'd1000, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFE4A8, 1);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1; mdop = 3'b000; da = 32'd12345; db = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy before reset: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL mid-op reset: busy %b hi %h lo %h expected 0/0/0", busy, hi, lo); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL discarded op leaked: done %b hi %h lo %h expected 0/0/0", done, hi, lo); end
    do_op("after reset", 3'b001, 32'd5, 32'd6, 32'h0, 32'd30, 0);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] e;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      e = model(op, a, b);
      do_op($sformatf("random op%0d %h,%h", op, a, b), op, a, b, e[63:32], e[31:0], 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_move();
    test_reserved();
    test_busy_ignore();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
